// File: rtl/dmem_arb_pkg.sv
// +----------------------------------------------------------------------+
// | Module   : dmem_arb_pkg                                              |
// | Purpose  : Size codes, byte-lane masks and alignment helpers shared  |
// |            by the DMEM port arbiter and its round-robin selector.    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

package dmem_arb_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [2:0] MASK_BYTE = 3'b001;
  localparam logic [2:0] MASK_HALF = 3'b011;
  localparam logic [2:0] MASK_WORD = 3'b111;

  // Lane mask the DMEM expects for a given access size; illegal size maps to no lanes.
  function automatic logic [2:0] size_to_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_to_mask = MASK_BYTE;
      SZ_HALF: size_to_mask = MASK_HALF;
      SZ_WORD: size_to_mask = MASK_WORD;
      default: size_to_mask = 3'b000;
    endcase
  endfunction

  // True for any access that must be rejected: misaligned half/word or the illegal size code.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = lsb[0];
      SZ_WORD: is_misaligned = |lsb;
      default: is_misaligned = 1'b1;
    endcase
  endfunction

  // Expands a lane mask into a 32-bit data mask used to zero-extend load data.
  function automatic logic [31:0] mask_to_bits(input logic [2:0] m);
    mask_to_bits = {{16{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_rr_select.sv
// +----------------------------------------------------------------------+
// | Module   : dmem_rr_select                                            |
// | Purpose  : Combinational round-robin scan that grants up to          |
// |            NUM_PORTS legal requests (plus any number of error        |
// |            requests) while blocking same-word store hazards.         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module dmem_rr_select
  import dmem_arb_pkg::*;
#(
  parameter int NUM_REQ   = 8,
  parameter int NUM_PORTS = 4,
  parameter int WADDR_W   = 8,
  parameter int IDX_W     = 3
) (
  input  logic [NUM_REQ-1:0]         i_valid,
  input  logic [NUM_REQ-1:0]         i_err,
  input  logic [NUM_REQ-1:0]         i_we,
  input  logic [NUM_REQ*WADDR_W-1:0] i_waddr,
  input  logic [IDX_W-1:0]           i_ptr,
  output logic [NUM_REQ-1:0]         o_gnt,
  output logic [NUM_PORTS-1:0]       o_port_vld,
  output logic [NUM_PORTS*IDX_W-1:0] o_port_idx,
  output logic [IDX_W-1:0]           o_last_idx,
  output logic                       o_any_gnt
);

  // Scan from the pointer; the k-th granted legal request lands on port k.
  always_comb begin
    int                 v_idx;
    int                 v_used;
    int                 v_cmp;
    logic               v_hz;
    logic [IDX_W-1:0]   v_pidx [NUM_PORTS];
    o_gnt      = '0;
    o_port_vld = '0;
    o_last_idx = '0;
    o_any_gnt  = 1'b0;
    v_idx      = 0;
    v_used     = 0;
    v_cmp      = 0;
    v_hz       = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) v_pidx[k] = '0;
    for (int s = 0; s < NUM_REQ; s++) begin
      v_idx = int'(i_ptr) + s;
      if (v_idx >= NUM_REQ) v_idx = v_idx - NUM_REQ;
      if (i_valid[v_idx]) begin
        if (i_err[v_idx]) begin
          // Rejected accesses never need a port, so they are always accepted.
          o_gnt[v_idx] = 1'b1;
          o_last_idx   = IDX_W'(v_idx);
          o_any_gnt    = 1'b1;
        end else if (v_used < NUM_PORTS) begin
          v_hz = 1'b0;
          for (int k = 0; k < NUM_PORTS; k++) begin
            if (k < v_used) begin
              v_cmp = int'(v_pidx[k]);
              if ((i_waddr[v_idx*WADDR_W +: WADDR_W] == i_waddr[v_cmp*WADDR_W +: WADDR_W]) &&
                  (i_we[v_idx] || i_we[v_cmp]))
                v_hz = 1'b1;
            end
          end
          if (!v_hz) begin
            o_port_vld[v_used] = 1'b1;
            v_pidx[v_used]     = IDX_W'(v_idx);
            v_used             = v_used + 1;
            o_gnt[v_idx]       = 1'b1;
            o_last_idx         = IDX_W'(v_idx);
            o_any_gnt          = 1'b1;
          end
        end
      end
    end
    for (int k = 0; k < NUM_PORTS; k++) o_port_idx[k*IDX_W +: IDX_W] = v_pidx[k];
  end

endmodule

`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
// +----------------------------------------------------------------------+
// | Module   : dmem_port_arbiter                                         |
// | Purpose  : Shares the 4-port byte-addressed DMEM among NUM_REQ       |
// |            requesters; owns the round-robin pointer, port muxing     |
// |            and the registered one-cycle-later responses.             |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NUM_REQ    = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_PORTS  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  input  logic [NUM_REQ-1:0]              i_req_we,
  input  logic [2*NUM_REQ-1:0]            i_req_size,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   i_req_addr,
  input  logic [NUM_REQ*32-1:0]           i_req_wdata,
  output logic [NUM_REQ-1:0]              o_req_gnt,
  output logic [NUM_REQ-1:0]              o_rsp_valid,
  output logic [NUM_REQ-1:0]              o_rsp_err,
  output logic [NUM_REQ*32-1:0]           o_rsp_data,
  output logic [3*NUM_PORTS-1:0]          o_dmem_we,
  output logic [3*NUM_PORTS-1:0]          o_dmem_re,
  output logic [ADDR_WIDTH*NUM_PORTS-1:0] o_dmem_addr,
  output logic [32*NUM_PORTS-1:0]         o_dmem_wdata,
  input  logic [32*NUM_PORTS-1:0]         i_dmem_rdata
);

  localparam int c_IDX_W = $clog2(NUM_REQ);
  localparam int c_WA_W  = ADDR_WIDTH - 2;

  logic [1:0]                   w_size [NUM_REQ];
  logic [NUM_REQ-1:0]           w_err;
  logic [NUM_REQ-1:0]           w_valid;
  logic [NUM_REQ*c_WA_W-1:0]    w_waddr;
  logic [NUM_REQ-1:0]           w_gnt;
  logic [NUM_PORTS-1:0]         w_port_vld;
  logic [NUM_PORTS*c_IDX_W-1:0] w_port_idx;
  logic [c_IDX_W-1:0]           w_last_idx;
  logic                         w_any_gnt;
  logic [NUM_REQ*32-1:0]        w_rsp_data_d;

  logic [c_IDX_W-1:0]           r_rr_ptr;
  logic [NUM_REQ-1:0]           r_rsp_valid;
  logic [NUM_REQ-1:0]           r_rsp_err;
  logic [NUM_REQ*32-1:0]        r_rsp_data;

  // Holding requests off while in reset keeps grants and DMEM enables at zero.
  assign w_valid = i_req_valid & {NUM_REQ{~rst}};

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
      assign w_size[i]                   = i_req_size[2*i +: 2];
      assign w_err[i]                    = is_misaligned(w_size[i], i_req_addr[i*ADDR_WIDTH +: 2]);
      assign w_waddr[i*c_WA_W +: c_WA_W] = i_req_addr[i*ADDR_WIDTH+2 +: c_WA_W];
    end
  endgenerate

  dmem_rr_select #(
    .NUM_REQ   (NUM_REQ),
    .NUM_PORTS (NUM_PORTS),
    .WADDR_W   (c_WA_W),
    .IDX_W     (c_IDX_W)
  ) u_select (
    .i_valid    (w_valid),
    .i_err      (w_err),
    .i_we       (i_req_we),
    .i_waddr    (w_waddr),
    .i_ptr      (r_rr_ptr),
    .o_gnt      (w_gnt),
    .o_port_vld (w_port_vld),
    .o_port_idx (w_port_idx),
    .o_last_idx (w_last_idx),
    .o_any_gnt  (w_any_gnt)
  );

  assign o_req_gnt = w_gnt;

  // Route each occupied port to its requester; idle ports drive all zeros.
  always_comb begin
    int v_i;
    o_dmem_we    = '0;
    o_dmem_re    = '0;
    o_dmem_addr  = '0;
    o_dmem_wdata = '0;
    v_i          = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (w_port_vld[k]) begin
        v_i = int'(w_port_idx[k*c_IDX_W +: c_IDX_W]);
        o_dmem_addr[k*ADDR_WIDTH +: ADDR_WIDTH] = i_req_addr[v_i*ADDR_WIDTH +: ADDR_WIDTH];
        if (i_req_we[v_i]) begin
          o_dmem_we[k*3 +: 3]     = size_to_mask(w_size[v_i]);
          o_dmem_wdata[k*32 +: 32] = i_req_wdata[v_i*32 +: 32];
        end else begin
          o_dmem_re[k*3 +: 3] = size_to_mask(w_size[v_i]);
        end
      end
    end
  end

  // Pick up each load's port read data, zero-extended to the access size.
  always_comb begin
    w_rsp_data_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (w_port_vld[k] && (int'(w_port_idx[k*c_IDX_W +: c_IDX_W]) == i) && !i_req_we[i])
          w_rsp_data_d[i*32 +: 32] = i_dmem_rdata[k*32 +: 32] & mask_to_bits(size_to_mask(w_size[i]));
      end
    end
  end

  // Register responses and advance the pointer past the last granted requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_rsp_valid <= '0;
      r_rsp_err   <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= w_gnt;
      r_rsp_err   <= w_gnt & w_err;
      r_rsp_data  <= w_rsp_data_d;
      if (w_any_gnt)
        r_rr_ptr <= (int'(w_last_idx) == NUM_REQ - 1) ? '0 : w_last_idx + 1'b1;
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_err   = r_rsp_err;
  assign o_rsp_data  = r_rsp_data;

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
// +----------------------------------------------------------------------+
// | Module   : tb_dmem_port_arbiter                                      |
// | Purpose  : Directed scoreboard bench for dmem_port_arbiter with a    |
// |            little-endian byte memory model behind the four ports.    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_dmem_port_arbiter;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    req_valid = '0;
  logic [7:0]    req_we    = '0;
  logic [15:0]   req_size  = '0;
  logic [79:0]   req_addr  = '0;
  logic [255:0]  req_wdata = '0;
  logic [7:0]    req_gnt;
  logic [7:0]    rsp_valid;
  logic [7:0]    rsp_err;
  logic [255:0]  rsp_data;
  logic [11:0]   dmem_we;
  logic [11:0]   dmem_re;
  logic [39:0]   dmem_addr;
  logic [127:0]  dmem_wdata;
  logic [127:0]  dmem_rdata;

  typedef struct {
    int          idx;
    logic        err;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          mon_found;
  logic [7:0]  mem [1024];

  dmem_port_arbiter #(.NUM_REQ(8), .ADDR_WIDTH(10), .NUM_PORTS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_req_valid  (req_valid),
    .i_req_we     (req_we),
    .i_req_size   (req_size),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_req_gnt    (req_gnt),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_err    (rsp_err),
    .o_rsp_data   (rsp_data),
    .o_dmem_we    (dmem_we),
    .o_dmem_re    (dmem_re),
    .o_dmem_addr  (dmem_addr),
    .o_dmem_wdata (dmem_wdata),
    .i_dmem_rdata (dmem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: reloads a known pattern in reset, otherwise commits masked writes at the edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'(i) ^ 8'hA5;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (dmem_we[k*3])   mem[dmem_addr[k*10 +: 10]]         <= dmem_wdata[k*32 +: 8];
        if (dmem_we[k*3+1]) mem[dmem_addr[k*10 +: 10] + 10'd1] <= dmem_wdata[k*32+8 +: 8];
        if (dmem_we[k*3+2]) begin
          mem[dmem_addr[k*10 +: 10] + 10'd2] <= dmem_wdata[k*32+16 +: 8];
          mem[dmem_addr[k*10 +: 10] + 10'd3] <= dmem_wdata[k*32+24 +: 8];
        end
      end
    end
  end

  // Read side returns four bytes from the port address; upper bytes are not masked here.
  always_comb begin
    dmem_rdata = '0;
    for (int k = 0; k < 4; k++)
      dmem_rdata[k*32 +: 32] = {mem[dmem_addr[k*10 +: 10] + 10'd3], mem[dmem_addr[k*10 +: 10] + 10'd2],
                                mem[dmem_addr[k*10 +: 10] + 10'd1], mem[dmem_addr[k*10 +: 10]]};
  end

  function automatic logic [31:0] init_word(input logic [9:0] a);
    logic [9:0] b;
    init_word = '0;
    for (int j = 0; j < 4; j++) begin
      b = a + 10'(j);
      init_word[8*j +: 8] = b[7:0] ^ 8'hA5;
    end
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic we, input logic [1:0] sz,
                         input logic [9:0] a, input logic [31:0] d);
    req_valid[i]        = 1'b1;
    req_we[i]           = we;
    req_size[2*i +: 2]  = sz;
    req_addr[10*i +: 10] = a;
    req_wdata[32*i +: 32] = d;
  endtask

  task automatic drop(input logic [7:0] m);
    req_valid = req_valid & ~m;
  endtask

  task automatic expect_rsp(input int i, input logic e, input logic [31:0] d);
    exp_t x;
    x.idx  = i;
    x.err  = e;
    x.data = d;
    x.due  = cyc + 1;
    q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented response must match a queued expectation due this cycle.
  always @(negedge clk) begin
    if (!rst) begin
      for (int j = q.size() - 1; j >= 0; j--) begin
        if (q[j].due < cyc) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rsp_missing[%0d]: got no response, expected one at cycle %0d", q[j].idx, q[j].due);
          q.delete(j);
        end
      end
      for (int i = 0; i < 8; i++) begin
        if (rsp_valid[i]) begin
          mon_found = -1;
          for (int j = 0; j < q.size(); j++)
            if (mon_found < 0 && q[j].idx == i) mon_found = j;
          n_cmp++;
          if (mon_found < 0) begin
            n_bad++;
            $display("FAIL rsp_unexpected[%0d]: got err=%0b data=0x%0h, expected no response", i, rsp_err[i], rsp_data[32*i +: 32]);
          end else begin
            if (rsp_err[i] !== q[mon_found].err || rsp_data[32*i +: 32] !== q[mon_found].data ||
                cyc != q[mon_found].due) begin
              n_bad++;
              $display("FAIL rsp[%0d]: got err=%0b data=0x%0h cyc=%0d, expected err=%0b data=0x%0h cyc=%0d",
                       i, rsp_err[i], rsp_data[32*i +: 32], cyc, q[mon_found].err, q[mon_found].data, q[mon_found].due);
            end
            q.delete(mon_found);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected bench completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with all requesters loading: nothing may be granted or enabled.
    for (int i = 0; i < 8; i++) set_req(i, 1'b0, 2'b10, 10'(32'h100 + 4*i), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_gnt",       128'(req_gnt), 128'h0);
    chk("reset_dmem_en",   128'({dmem_we, dmem_re}), 128'h0);
    chk("reset_rsp_valid", 128'(rsp_valid), 128'h0);
    chk("reset_rsp_err",   128'(rsp_err), 128'h0);
    chk("reset_rsp_data",  rsp_data[127:0] | rsp_data[255:128], 128'h0);
    tick();
    rst = 1'b0;

    // Eight loads from pointer 0: 0-3 then 4-7.
    @(negedge clk);
    chk("rr_gnt_c0",  128'(req_gnt), 128'h0F);
    chk("rr_re_c0",   128'(dmem_re), 128'hFFF);
    chk("rr_addr_c0", 128'(dmem_addr), 128'({10'h10C, 10'h108, 10'h104, 10'h100}));
    for (int i = 0; i < 4; i++) expect_rsp(i, 1'b0, init_word(10'(32'h100 + 4*i)));
    tick();
    drop(8'h0F);
    @(negedge clk);
    chk("rr_gnt_c1", 128'(req_gnt), 128'hF0);
    for (int i = 4; i < 8; i++) expect_rsp(i, 1'b0, init_word(10'(32'h100 + 4*i)));
    tick();
    drop(8'hFF);

    // Store then load of the same word in consecutive cycles (pointer 0).
    set_req(0, 1'b1, 2'b10, 10'h010, 32'hDEADBEEF);
    @(negedge clk);
    chk("st_gnt",   128'(req_gnt), 128'h01);
    chk("st_we",    128'({dmem_we, dmem_re}), 128'({12'h007, 12'h000}));
    chk("st_addr",  128'(dmem_addr), 128'h010);
    chk("st_wdata", dmem_wdata, 128'hDEADBEEF);
    expect_rsp(0, 1'b0, 32'h0);
    tick();
    drop(8'h01);
    set_req(1, 1'b0, 2'b10, 10'h010, 32'h0);
    @(negedge clk);
    chk("ld_gnt", 128'(req_gnt), 128'h02);
    chk("ld_re",  128'({dmem_we, dmem_re}), 128'({12'h000, 12'h007}));
    expect_rsp(1, 1'b0, 32'hDEADBEEF);
    tick();
    drop(8'h02);

    // Same-word hazard: store wins, load waits one cycle (pointer 2).
    set_req(2, 1'b1, 2'b10, 10'h020, 32'hCAFEF00D);
    set_req(3, 1'b0, 2'b00, 10'h021, 32'h0);
    @(negedge clk);
    chk("hz_gnt0", 128'(req_gnt), 128'h04);
    expect_rsp(2, 1'b0, 32'h0);
    tick();
    drop(8'h04);
    @(negedge clk);
    chk("hz_gnt1", 128'(req_gnt), 128'h08);
    expect_rsp(3, 1'b0, 32'h000000F0);
    tick();
    drop(8'h08);

    // Misaligned half, misaligned word, illegal size: granted, no enables (pointer 4).
    set_req(4, 1'b1, 2'b01, 10'h005, 32'h00001234);
    set_req(5, 1'b0, 2'b10, 10'h006, 32'h0);
    set_req(6, 1'b1, 2'b11, 10'h040, 32'h99999999);
    @(negedge clk);
    chk("err_gnt", 128'(req_gnt), 128'h70);
    chk("err_en",  128'({dmem_we, dmem_re}), 128'h0);
    for (int i = 4; i < 7; i++) expect_rsp(i, 1'b1, 32'h0);
    tick();
    drop(8'h70);

    // Word store, byte merge, then reads back (pointer 7).
    set_req(7, 1'b1, 2'b10, 10'h030, 32'h11223344);
    @(negedge clk);
    chk("mrg_gnt0", 128'(req_gnt), 128'h80);
    expect_rsp(7, 1'b0, 32'h0);
    tick();
    drop(8'h80);
    set_req(0, 1'b1, 2'b00, 10'h031, 32'h000000AB);
    @(negedge clk);
    chk("mrg_gnt1", 128'(req_gnt), 128'h01);
    chk("mrg_we",   128'(dmem_we), 128'h001);
    expect_rsp(0, 1'b0, 32'h0);
    tick();
    drop(8'h01);
    set_req(1, 1'b0, 2'b10, 10'h030, 32'h0);
    set_req(2, 1'b0, 2'b10, 10'h040, 32'h0);
    @(negedge clk);
    chk("mrg_gnt2",  128'(req_gnt), 128'h06);
    chk("mrg_addr2", 128'(dmem_addr), 128'({20'h0, 10'h040, 10'h030}));
    expect_rsp(1, 1'b0, 32'h1122AB44);
    expect_rsp(2, 1'b0, 32'hE6E7E4E5);
    tick();
    drop(8'h06);

    // Two loads to one word plus a half load, all granted together (pointer 3).
    set_req(3, 1'b0, 2'b10, 10'h010, 32'h0);
    set_req(4, 1'b0, 2'b10, 10'h010, 32'h0);
    set_req(5, 1'b0, 2'b01, 10'h004, 32'h0);
    @(negedge clk);
    chk("ll_gnt", 128'(req_gnt), 128'h38);
    expect_rsp(3, 1'b0, 32'hDEADBEEF);
    expect_rsp(4, 1'b0, 32'hDEADBEEF);
    expect_rsp(5, 1'b0, 32'h0000A0A1);
    tick();
    drop(8'h38);

    // Reset in the middle of traffic (pointer 6).
    for (int i = 0; i < 8; i++) set_req(i, 1'b0, 2'b10, 10'(32'h100 + 4*i), 32'h0);
    @(negedge clk);
    chk("mid_gnt", 128'(req_gnt), 128'hC3);
    @(posedge clk);
    #1;
    chk("mid_rsp_before", 128'(rsp_valid), 128'hC3);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rsp_cleared", 128'(rsp_valid), 128'h0);
    chk("mid_rst_gnt",     128'(req_gnt), 128'h0);
    chk("mid_rst_en",      128'({dmem_we, dmem_re}), 128'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_gnt", 128'(req_gnt), 128'h0F);
    for (int i = 0; i < 4; i++) expect_rsp(i, 1'b0, init_word(10'(32'h100 + 4*i)));
    tick();
    drop(8'hFF);

    repeat (3) @(negedge clk);
    chk("queue_drained", 128'(q.size()), 128'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the 4-port byte-addressed data memory among NUM_REQ load/store requesters (vector lane LSUs).
- Each cycle it grants up to 4 requests in round-robin order and maps granted requests onto DMEM ports.
- It translates access size into the 3-bit byte-lane masks the DMEM uses, blocks same-word write hazards, rejects misaligned accesses, and returns registered responses one cycle after grant.

Parameters:
- NUM_REQ, 8: number of requesters (2..16).
- ADDR_WIDTH, 10: byte address width; matches the DMEM.
- NUM_PORTS, 4: DMEM ports; fixed at 4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request; held stable until req_gnt.
- req_we  in  NUM_REQ  1 = store, 0 = load.
- req_size  in  2*NUM_REQ  per requester: 00 byte, 01 half, 10 word, 11 illegal.
- req_addr  in  NUM_REQ*ADDR_WIDTH  byte address.
- req_wdata  in  NUM_REQ*32  store data, right-aligned.
- req_gnt  out  NUM_REQ  combinational grant in the request cycle.
- rsp_valid  out  NUM_REQ  registered, high the cycle after grant.
- rsp_err  out  NUM_REQ  registered; misaligned or illegal size.
- rsp_data  out  NUM_REQ*32  registered load data, zero-extended; 0 for stores and errors.
- dmem_we  out  3*NUM_PORTS  per-port write mask.
- dmem_re  out  3*NUM_PORTS  per-port read mask.
- dmem_addr  out  ADDR_WIDTH*NUM_PORTS  per-port address.
- dmem_wdata  out  32*NUM_PORTS  per-port write data.
- dmem_rdata  in  32*NUM_PORTS  per-port combinational read data.

Behaviour:
- Reset (async, rst=1): rr_ptr=0, rsp_valid=0, rsp_err=0, rsp_data=0. While rst=1, req_gnt and all dmem_we/dmem_re are forced to 0, so no writes occur.
- Mask encoding, used for both dmem_we and dmem_re: byte 3'b001, half 3'b011, word 3'b111.
  - Stores drive dmem_we with the mask and dmem_re=0.
  - Loads drive dmem_re with the mask and dmem_we=0.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=0; size 11 is always an error. Error requests:
  - are granted but consume no port;
  - produce rsp_valid=1, rsp_err=1, rsp_data=0 the next cycle;
  - never touch memory.
- Selection (combinational, same cycle): scan requesters starting at rr_ptr, wrapping modulo NUM_REQ.
  - Error requests are always granted.
  - A legal request is granted if a port remains and it has no hazard against requests already granted this cycle.
  - The k-th legal grant in scan order drives port k.
  - Unused ports drive masks 0, addr 0, wdata 0.
- Hazard: two legal requests with equal word address (addr[ADDR_WIDTH-1:2]) where at least one is a store. The later one in scan order is not granted this cycle. Two loads to the same word are both granted.
- Latency: a store commits at the rising edge ending the grant cycle. Load data is sampled from dmem_rdata at that same edge into rsp_data. rsp_valid is high for exactly one cycle (N+1), and stores also get rsp_valid with rsp_data=0.
- A load in the cycle after a store to the same word sees the new data.
- Pointer update: if any grant occurred, rr_ptr <= (index of last granted requester + 1) mod NUM_REQ; otherwise rr_ptr is unchanged.
- Starvation bound: a continuously requesting, hazard-free requester is granted within ceil(NUM_REQ/NUM_PORTS) cycles.
- Back-to-back: a requester may present a new request in the cycle after its grant and be granted again.
- Address arithmetic: aligned accesses never cross the top of memory, so no wrap handling is needed.
- Reset asserted mid-operation: pending rsp_valid is cleared immediately (async). No responses are produced for grants that were in flight.

Decomposition:
- Package dmem_arb_pkg holds:
  - size codes SZ_BYTE, SZ_HALF, SZ_WORD;
  - masks MASK_BYTE, MASK_HALF, MASK_WORD;
  - function size_to_mask;
  - function is_misaligned(size, addr[1:0]).
- One sub-module, dmem_rr_select: combinational round-robin scan with hazard check. It outputs the grant vector, a per-port requester index with a valid bit, and the last-granted index.
- Top level owns rr_ptr, the response registers and the port muxing.

Test Plan:
- Reset, then req0 stores word 0xDEADBEEF @0x010. Next cycle req1 loads word @0x010 -> req1 granted on port 0; rsp_valid[1] the following cycle with rsp_data 0xDEADBEEF.
- All 8 requesters load, each dropping its request after grant, rr_ptr=0 -> cycle 0 grants 0-3 on ports 0-3 with rr_ptr->4; cycle 1 grants 4-7 with rr_ptr->0; each rsp_valid is one cycle after its own grant.
- rr_ptr=0: req2 stores word @0x020 and req3 loads byte @0x021 in the same cycle -> only req2 granted. req3 is granted next cycle and returns the new byte, zero-extended.
- req4 issues half @0x005, req5 word @0x006, req6 size 11 -> all granted, no DMEM enables. Next cycle rsp_err=1 and rsp_data=0 for all three; memory is unchanged.
- Word 0x11223344 @0x030, then byte store 0xAB @0x031, then word load @0x030 -> 0x1122AB44.
- rst asserted while all req_valid are high with loads in flight -> req_gnt=0, enables 0, rsp_valid cleared immediately. After release the first grant starts at requester 0.
